mux_n_seq: RTL and testbench

Parametrised, registered N:1 multiplexer with a direct-select mode and an auto-scan mode. Each cycle it selects one channel of a packed input bus, presents it on a registered output, and reports which channel produced it. Scan mode sweeps all channels round-robin, optionally frozen by `hold`. It sits behind multi-channel sample sources and generalises the combinational 8:1 bit mux to any width and channel count.

---
 rtl/mux_pkg.sv | 9 +
 rtl/mux_nto1.sv | 21 ++
 rtl/mux_n_seq.sv | 118 +++++++++++
 tb/tb_mux_n_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the sequenced N:1 multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} mux_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 channel selector; an index past the last channel yields zero.
module mux_nto1 #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    input  logic [SEL_W-1:0]          idx_i,
    output logic [WIDTH-1:0]          q_o
);

    always_comb begin
        q_o = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (idx_i == SEL_W'(c)) begin
                q_o = d_i[c*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_seq.sv
// Registered N:1 multiplexer with direct-select and round-robin scan modes.
module mux_n_seq
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          S,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic                      hold,
    output logic [WIDTH-1:0]          Y,
    output logic                      Y_valid,
    output logic [SEL_W-1:0]          Y_chan,
    output logic                      sel_err,
    output logic                      wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    mux_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] cur_ptr;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] sel_data;

    // Entering SCAN from any other state restarts the sweep at channel 0.
    assign cur_ptr = (state_q == SCAN) ? ptr_q : '0;
    assign idx     = (state_d == SCAN) ? cur_ptr : S;

    mux_nto1 #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .SEL_W   (SEL_W)
    ) u_sel (
        .d_i  (D),
        .idx_i(idx),
        .q_o  (sel_data)
    );

    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    always_comb begin
        y_d     = y_q;
        chan_d  = chan_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        ptr_d   = ptr_q;
        unique case (state_d)
            DIRECT: begin
                if (S > LAST) begin
                    err_d = 1'b1;
                end else begin
                    y_d     = sel_data;
                    chan_d  = S;
                    valid_d = 1'b1;
                end
            end
            SCAN: begin
                y_d     = sel_data;
                chan_d  = cur_ptr;
                valid_d = 1'b1;
                ptr_d   = cur_ptr;
                if (!hold) begin
                    if (cur_ptr == LAST) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = cur_ptr + SEL_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            chan_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Y       = y_q;
    assign Y_valid = valid_q;
    assign Y_chan  = chan_q;
    assign sel_err = err_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_n_seq.sv
// Directed bench for mux_n_seq: an 8-channel and a 6-channel instance, 4 bits per channel.
module tb_mux_n_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en8 = 1'b0, mode8 = 1'b0, hold8 = 1'b0;
    logic [2:0]  s8 = '0;
    logic [31:0] d8 = 32'h76543210;
    logic [3:0]  y8;
    logic [2:0]  ch8;
    logic        v8, e8, w8;

    logic        en6 = 1'b0, mode6 = 1'b0, hold6 = 1'b0;
    logic [2:0]  s6 = '0;
    logic [23:0] d6 = 24'h987654;
    logic [3:0]  y6;
    logic [2:0]  ch6;
    logic        v6, e6, w6;

    int n_pass  = 0;
    int n_total = 0;

    mux_n_seq #(.WIDTH(4), .CHANNELS(8)) u8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .S(s8), .D(d8), .hold(hold8),
        .Y(y8), .Y_valid(v8), .Y_chan(ch8), .sel_err(e8), .wrap(w8)
    );

    mux_n_seq #(.WIDTH(4), .CHANNELS(6)) u6 (
        .clk(clk), .rst(rst), .en(en6), .mode(mode6), .S(s6), .D(d6), .hold(hold6),
        .Y(y6), .Y_valid(v6), .Y_chan(ch6), .sel_err(e6), .wrap(w6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view of u8 outputs: {Y, Y_chan, Y_valid, sel_err, wrap}
    function automatic logic [9:0] pk8(input logic [3:0] y, input logic [2:0] c,
                                       input logic v, input logic e, input logic w);
        return {y, c, v, e, w};
    endfunction

    task automatic test_reset();
        en8 = 1'b1; mode8 = 1'b0; s8 = 3'd5;
        step();
        n_total++;
        if ({y8, ch8, v8} !== {4'd5, 3'd5, 1'b1}) $display("FAIL reset_pre y/ch/v got %h/%0d/%b want 5/5/1", y8, ch8, v8);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== 10'd0) $display("FAIL reset_async got %h want 000", pk8(y8, ch8, v8, e8, w8));
        else n_pass++;
        en8 = 1'b0;
        step();
        rst = 1'b0;
        step();
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== 10'd0) $display("FAIL reset_release_idle got %h want 000", pk8(y8, ch8, v8, e8, w8));
        else n_pass++;
        n_total++;
        if ({y6, ch6, v6, e6, w6} !== 10'd0) $display("FAIL reset_u6 got %h want 000", {y6, ch6, v6, e6, w6});
        else n_pass++;
    endtask

    task automatic test_direct();
        en8 = 1'b1; mode8 = 1'b0; s8 = 3'd5;
        step();
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== pk8(4'd5, 3'd5, 1'b1, 1'b0, 1'b0))
            $display("FAIL direct_s5 got %h want %h", pk8(y8, ch8, v8, e8, w8), pk8(4'd5, 3'd5, 1'b1, 1'b0, 1'b0));
        else n_pass++;
        s8 = 3'd2;
        step();
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== pk8(4'd2, 3'd2, 1'b1, 1'b0, 1'b0))
            $display("FAIL direct_s2 got %h want %h", pk8(y8, ch8, v8, e8, w8), pk8(4'd2, 3'd2, 1'b1, 1'b0, 1'b0));
        else n_pass++;
    endtask

    task automatic test_scan_wrap();
        logic [2:0] c;
        mode8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            c = 3'(i % 8);
            n_total++;
            if (pk8(y8, ch8, v8, e8, w8) !== pk8({1'b0, c}, c, 1'b1, 1'b0, (c == 3'd7)))
                $display("FAIL scan_wrap[%0d] got %h want %h", i, pk8(y8, ch8, v8, e8, w8),
                         pk8({1'b0, c}, c, 1'b1, 1'b0, (c == 3'd7)));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        en8 = 1'b0;
        step();
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== pk8(4'd1, 3'd1, 1'b0, 1'b0, 1'b0))
            $display("FAIL idle_hold got %h want %h", pk8(y8, ch8, v8, e8, w8), pk8(4'd1, 3'd1, 1'b0, 1'b0, 1'b0));
        else n_pass++;
        en8 = 1'b1; mode8 = 1'b1; hold8 = 1'b0;
        repeat (3) step();
        n_total++;
        if (ch8 !== 3'd2) $display("FAIL hold_pre chan got %0d want 2", ch8);
        else n_pass++;
        hold8 = 1'b1;
        step();
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== pk8(4'd3, 3'd3, 1'b1, 1'b0, 1'b0))
            $display("FAIL hold_first got %h want %h", pk8(y8, ch8, v8, e8, w8), pk8(4'd3, 3'd3, 1'b1, 1'b0, 1'b0));
        else n_pass++;
        d8 = 32'h76549210;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (pk8(y8, ch8, v8, e8, w8) !== pk8(4'd9, 3'd3, 1'b1, 1'b0, 1'b0))
                $display("FAIL hold_live[%0d] got %h want %h", i, pk8(y8, ch8, v8, e8, w8), pk8(4'd9, 3'd3, 1'b1, 1'b0, 1'b0));
            else n_pass++;
        end
        hold8 = 1'b0;
        step();
        n_total++;
        if ({y8, ch8} !== {4'd9, 3'd3}) $display("FAIL hold_release y/ch got %h/%0d want 9/3", y8, ch8);
        else n_pass++;
        step();
        n_total++;
        if ({y8, ch8} !== {4'd4, 3'd4}) $display("FAIL hold_resume y/ch got %h/%0d want 4/4", y8, ch8);
        else n_pass++;
        repeat (2) step();
        hold8 = 1'b1;
        step();
        n_total++;
        if ({ch8, w8} !== {3'd7, 1'b0}) $display("FAIL hold_last ch/wrap got %0d/%b want 7/0", ch8, w8);
        else n_pass++;
        hold8 = 1'b0;
        step();
        n_total++;
        if ({ch8, w8} !== {3'd7, 1'b1}) $display("FAIL hold_last_release ch/wrap got %0d/%b want 7/1", ch8, w8);
        else n_pass++;
        step();
        n_total++;
        if ({ch8, w8} !== {3'd0, 1'b0}) $display("FAIL hold_after_wrap ch/wrap got %0d/%b want 0/0", ch8, w8);
        else n_pass++;
        d8 = 32'h76543210;
    endtask

    task automatic test_mode_change();
        repeat (3) step();
        n_total++;
        if (ch8 !== 3'd3) $display("FAIL mode_pre chan got %0d want 3", ch8);
        else n_pass++;
        mode8 = 1'b0; s8 = 3'd5;
        step();
        n_total++;
        if (pk8(y8, ch8, v8, e8, w8) !== pk8(4'd5, 3'd5, 1'b1, 1'b0, 1'b0))
            $display("FAIL mode_direct got %h want %h", pk8(y8, ch8, v8, e8, w8), pk8(4'd5, 3'd5, 1'b1, 1'b0, 1'b0));
        else n_pass++;
        mode8 = 1'b1;
        step();
        n_total++;
        if ({y8, ch8, v8} !== {4'd0, 3'd0, 1'b1}) $display("FAIL mode_rescan y/ch/v got %h/%0d/%b want 0/0/1", y8, ch8, v8);
        else n_pass++;
        s8 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            mode8 = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
            n_total++;
            if (ch8 !== ((i % 2 == 0) ? 3'd2 : 3'd0)) $display("FAIL mode_toggle[%0d] chan got %0d want %0d", i, ch8, (i % 2 == 0) ? 2 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_sel_err();
        en6 = 1'b1; mode6 = 1'b0; s6 = 3'd2;
        step();
        n_total++;
        if ({y6, ch6, v6, e6} !== {4'd6, 3'd2, 1'b1, 1'b0}) $display("FAIL err_pre got %h want %h", {y6, ch6, v6, e6}, {4'd6, 3'd2, 1'b1, 1'b0});
        else n_pass++;
        s6 = 3'd6;
        for (int i = 0; i < 2; i++) begin
            step();
            n_total++;
            if ({y6, ch6, v6, e6, w6} !== {4'd6, 3'd2, 1'b0, 1'b1, 1'b0})
                $display("FAIL err_s6[%0d] got %h want %h", i, {y6, ch6, v6, e6, w6}, {4'd6, 3'd2, 1'b0, 1'b1, 1'b0});
            else n_pass++;
        end
        s6 = 3'd5;
        step();
        n_total++;
        if ({y6, ch6, v6, e6} !== {4'd9, 3'd5, 1'b1, 1'b0}) $display("FAIL err_s5 got %h want %h", {y6, ch6, v6, e6}, {4'd9, 3'd5, 1'b1, 1'b0});
        else n_pass++;
        s6 = 3'd7;
        step();
        n_total++;
        if ({y6, ch6, v6, e6} !== {4'd9, 3'd5, 1'b0, 1'b1}) $display("FAIL err_s7 got %h want %h", {y6, ch6, v6, e6}, {4'd9, 3'd5, 1'b0, 1'b1});
        else n_pass++;
        step();
        en6 = 1'b0;
        step();
        n_total++;
        if ({v6, e6} !== 2'b00) $display("FAIL err_idle v/err got %b%b want 00", v6, e6);
        else n_pass++;
    endtask

    task automatic test_scan6();
        logic [2:0] c;
        en6 = 1'b1; mode6 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            c = 3'(i % 6);
            n_total++;
            if ({y6, ch6, v6, w6} !== {4'(c + 3'd4), c, 1'b1, (c == 3'd5)})
                $display("FAIL scan6[%0d] got %h want %h", i, {y6, ch6, v6, w6}, {4'(c + 3'd4), c, 1'b1, (c == 3'd5)});
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_direct();
        test_scan_wrap();
        test_hold();
        test_mode_change();
        test_sel_err();
        test_scan6();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
